// File: rtl/rng_ram_filler.sv
// rtl/rng_ram_filler.sv - fills one RAM word per request with (optionally debiased) entropy bits
module rng_ram_filler #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEBIAS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_rng,
    input  logic [ADDR_W-1:0] addr_rng,
    output logic              ack_rng,
    input  logic              entropy_bit_i,
    input  logic              entropy_valid_i,
    output logic              ram_cyc_a,
    output logic              ram_stb_a,
    output logic [3:0]        ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_in_a,
    input  logic              ram_ack_a,
    input  logic              ram_stall_a,
    output logic              busy_o,
    output logic [15:0]       words_written_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pair_valid_q, pair_valid_d;
    logic                pair_bit_q, pair_bit_d;
    logic                cyc_q, stb_q, ack_rng_q;
    logic [15:0]         words_q;
    logic                shift_en, shift_bit, word_full;

    // A debiased pair emits its first bit when the two bits differ (01 -> 0, 10 -> 1).
    always_comb begin
        shift_en     = 1'b0;
        shift_bit    = 1'b0;
        pair_valid_d = pair_valid_q;
        pair_bit_d   = pair_bit_q;
        if (state_q == S_COLLECT && entropy_valid_i) begin
            if (DEBIAS == 0) begin
                shift_en  = 1'b1;
                shift_bit = entropy_bit_i;
            end else if (!pair_valid_q) begin
                pair_valid_d = 1'b1;
                pair_bit_d   = entropy_bit_i;
            end else begin
                pair_valid_d = 1'b0;
                pair_bit_d   = 1'b0;
                if (pair_bit_q != entropy_bit_i) begin
                    shift_en  = 1'b1;
                    shift_bit = pair_bit_q;
                end
            end
        end
        word_d    = shift_en ? {word_q[DATA_W-2:0], shift_bit} : word_q;
        cnt_d     = cnt_q + CNT_W'(shift_en);
        word_full = shift_en && (cnt_q == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            word_q       <= '0;
            cnt_q        <= '0;
            pair_valid_q <= 1'b0;
            pair_bit_q   <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            ack_rng_q    <= 1'b0;
            words_q      <= '0;
        end else begin
            ack_rng_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (we_rng) begin
                        addr_q       <= addr_rng;
                        word_q       <= '0;
                        cnt_q        <= '0;
                        pair_valid_q <= 1'b0;
                        pair_bit_q   <= 1'b0;
                        state_q      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    word_q       <= word_d;
                    cnt_q        <= cnt_d;
                    pair_valid_q <= pair_valid_d;
                    pair_bit_q   <= pair_bit_d;
                    if (word_full) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!ram_stall_a) begin
                        stb_q <= 1'b0;
                        if (ram_ack_a) begin
                            cyc_q     <= 1'b0;
                            ack_rng_q <= 1'b1;
                            words_q   <= words_q + 16'd1;
                            state_q   <= S_DONE;
                        end else begin
                            state_q <= S_WAIT_ACK;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (ram_ack_a) begin
                        cyc_q     <= 1'b0;
                        ack_rng_q <= 1'b1;
                        words_q   <= words_q + 16'd1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack_rng         = ack_rng_q;
    assign ram_cyc_a       = cyc_q;
    assign ram_stb_a       = stb_q;
    assign ram_we_a        = {4{cyc_q}};
    assign ram_addr_a      = cyc_q ? addr_q : '0;
    assign ram_data_in_a   = cyc_q ? word_q : '0;
    assign busy_o          = (state_q != S_IDLE);
    assign words_written_o = words_q;
endmodule

// File: tb/tb_rng_ram_filler.sv
// tb/tb_rng_ram_filler.sv - randomized check of rng_ram_filler (raw and debiased) against a bit-stream model
module tb_rng_ram_filler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ent_bit, ent_valid;
    logic        we[2];
    logic [8:0]  addr[2];
    logic        ack_rng[2], cyc[2], stb[2], busy[2];
    logic [3:0]  rwe[2];
    logic [8:0]  raddr[2];
    logic [31:0] rdata[2];
    logic        rack[2], rstall[2];
    logic [15:0] words[2];

    logic        ack_r[2], man_ack[2], comb_mode[2], hold[2];

    rng_ram_filler #(.ADDR_W(9), .DATA_W(32), .DEBIAS(0)) u_raw (
        .clk_i(clk), .rst_i(rst), .we_rng(we[0]), .addr_rng(addr[0]), .ack_rng(ack_rng[0]),
        .entropy_bit_i(ent_bit), .entropy_valid_i(ent_valid),
        .ram_cyc_a(cyc[0]), .ram_stb_a(stb[0]), .ram_we_a(rwe[0]), .ram_addr_a(raddr[0]),
        .ram_data_in_a(rdata[0]), .ram_ack_a(rack[0]), .ram_stall_a(rstall[0]),
        .busy_o(busy[0]), .words_written_o(words[0]));

    rng_ram_filler #(.ADDR_W(9), .DATA_W(32), .DEBIAS(1)) u_vn (
        .clk_i(clk), .rst_i(rst), .we_rng(we[1]), .addr_rng(addr[1]), .ack_rng(ack_rng[1]),
        .entropy_bit_i(ent_bit), .entropy_valid_i(ent_valid),
        .ram_cyc_a(cyc[1]), .ram_stb_a(stb[1]), .ram_we_a(rwe[1]), .ram_addr_a(raddr[1]),
        .ram_data_in_a(rdata[1]), .ram_ack_a(rack[1]), .ram_stall_a(rstall[1]),
        .busy_o(busy[1]), .words_written_o(words[1]));

    // Slave: registered one-cycle ack, or same-cycle ack when comb_mode is set.
    assign rack[0] = man_ack[0] | (comb_mode[0] ? (cyc[0] & stb[0] & ~rstall[0]) : ack_r[0]);
    assign rack[1] = man_ack[1] | (comb_mode[1] ? (cyc[1] & stb[1] & ~rstall[1]) : ack_r[1]);

    int          total = 0, bad = 0;
    int          edge_n = 0;
    int          n_acc[2], n_stb[2], n_ack[2], acc_edge[2], ack_edge[2], req_edge[2];
    logic [8:0]  cap_addr[2];
    logic [31:0] cap_data[2];
    logic [3:0]  cap_we[2];
    int          exp_words[2];
    bit          src[$];
    bit          dq[$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ack_r[i] <= cyc[i] & stb[i] & ~rstall[i] & ~hold[i] & ~rst;
            if (cyc[i] && stb[i] && !rstall[i]) begin
                n_acc[i]++;
                cap_addr[i] = raddr[i];
                cap_data[i] = rdata[i];
                cap_we[i]   = rwe[i];
                acc_edge[i] = edge_n;
            end
            if (stb[i]) n_stb[i]++;
            if (ack_rng[i]) begin
                n_ack[i]++;
                ack_edge[i] = edge_n;
            end
            if (we[i] && !busy[i] && !rst) req_edge[i] = edge_n;
        end
        edge_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: first 32 valid bits MSB-first, or first 32 unequal pairs' leading bits.
    function automatic logic [31:0] model_word(input bit vn);
        logic [31:0] w = '0;
        int n = 0;
        if (!vn) begin
            for (int j = 0; j < 32 && j < dq.size(); j++) w = {w[30:0], dq[j]};
        end else begin
            for (int j = 0; j + 1 < dq.size() && n < 32; j += 2)
                if (dq[j] != dq[j+1]) begin
                    w = {w[30:0], dq[j]};
                    n++;
                end
        end
        return w;
    endfunction

    task automatic collect(input int i, input logic [8:0] a, input int gap, input bit rnd_gap,
                           input int stray_at, input int stall);
        bit done = 0;
        bit v, b;
        dq.delete();
        rstall[i] = (stall > 0);
        @(negedge clk);
        we[i] = 1'b1;
        addr[i] = a;
        @(posedge clk);
        @(negedge clk);
        we[i] = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            v = rnd_gap ? ($urandom_range(3) != 0) : (c % (gap + 1) == 0);
            if (v && src.size() > 0) b = src.pop_front();
            else b = bit'($urandom_range(1));
            ent_valid = v;
            ent_bit = b;
            if (v) dq.push_back(b);
            we[i] = (c == stray_at);
            if (c == stray_at) addr[i] = 9'h1FF;
            @(posedge clk);
            #1;
            if (cyc[i]) done = 1;
            @(negedge clk);
            we[i] = 1'b0;
        end
        ent_valid = 1'b0;
        src.delete();
        if (!done) chk("collect_timeout", 32'd0, 32'd1);
    endtask

    task automatic complete(input int i, input logic [8:0] a, input bit use_model,
                            input logic [31:0] fixed, input int stall, input bit lat_chk);
        int acc0 = n_acc[i] - 0, ack0 = n_ack[i], stb0 = n_stb[i];
        logic [31:0] exp_d = use_model ? model_word(i == 1) : fixed;
        logic [31:0] d0 = rdata[i];
        logic [8:0]  a0 = raddr[i];
        bit got = 0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk("stall_stb", {31'd0, stb[i]}, 32'd1);
            chk("stall_data", rdata[i], d0);
            chk("stall_addr", {23'd0, raddr[i]}, {23'd0, a0});
        end
        @(negedge clk);
        rstall[i] = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(posedge clk);
            #1;
            if (n_ack[i] != ack0) got = 1;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        exp_words[i]++;
        chk("acc_cnt", n_acc[i] - acc0, 32'd1);
        chk("ack_cnt", n_ack[i] - ack0, 32'd1);
        chk("stb_cycles", n_stb[i] - stb0, stall + 1);
        chk("addr", {23'd0, cap_addr[i]}, {23'd0, a});
        chk("data", cap_data[i], exp_d);
        chk("we", {28'd0, cap_we[i]}, 32'hF);
        chk("words", {16'd0, words[i]}, exp_words[i]);
        chk("idle_cyc", {31'd0, cyc[i]}, 32'd0);
        chk("idle_busy", {31'd0, busy[i]}, 32'd0);
        if (lat_chk) begin
            chk("lat_stb", acc_edge[i] - req_edge[i], 32'd33);
            chk("lat_ack", ack_edge[i] - req_edge[i], 32'd35);
        end
        if (comb_mode[i]) chk("comb_ack_lat", ack_edge[i] - acc_edge[i], 32'd1);
    endtask

    initial begin
        logic [31:0] pat;
        bit pp[8];
        int acks_before;
        rst = 1'b1;
        ent_bit = 1'b0;
        ent_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            we[i] = 0; addr[i] = '0; rstall[i] = 0; man_ack[i] = 0; comb_mode[i] = 0; hold[i] = 0;
            n_acc[i] = 0; n_stb[i] = 0; n_ack[i] = 0; exp_words[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_cyc", {31'd0, cyc[i]}, 32'd0);
            chk("rst_stb", {31'd0, stb[i]}, 32'd0);
            chk("rst_ackrng", {31'd0, ack_rng[i]}, 32'd0);
            chk("rst_words", {16'd0, words[i]}, 32'd0);
            chk("rst_data", rdata[i], 32'd0);
        end

        // Raw fixed pattern with latency check
        pat = 32'hA5A5A5A5;
        for (int j = 31; j >= 0; j--) src.push_back(pat[j]);
        collect(0, 9'h005, 0, 0, -1, 0);
        complete(0, 9'h005, 0, 32'hA5A5A5A5, 0, 1);

        // Debias pattern 01,00,10,11
        pp = '{0, 1, 0, 0, 1, 0, 1, 1};
        repeat (16) for (int j = 0; j < 8; j++) src.push_back(pp[j]);
        collect(1, 9'h0C7, 0, 0, -1, 0);
        complete(1, 9'h0C7, 0, 32'h55555555, 0, 0);

        // Stalled strobe
        collect(0, 9'h112, 0, 0, -1, 5);
        complete(0, 9'h112, 1, 32'd0, 5, 0);

        // Same-cycle ack skips WAIT_ACK
        comb_mode[0] = 1'b1;
        collect(0, 9'h07E, 0, 0, -1, 0);
        complete(0, 9'h07E, 1, 32'd0, 0, 0);
        comb_mode[0] = 1'b0;

        // Stray request and valid gaps on both flavours
        collect(0, 9'h0A3, 3, 0, 6, 0);
        complete(0, 9'h0A3, 1, 32'd0, 0, 0);
        collect(1, 9'h150, 3, 0, 9, 0);
        complete(1, 9'h150, 1, 32'd0, 0, 0);

        // Reset while waiting for ack
        hold[0] = 1'b1;
        acks_before = n_ack[0];
        collect(0, 9'h033, 0, 0, -1, 0);
        @(posedge clk);
        #1;
        chk("wait_cyc", {31'd0, cyc[0]}, 32'd1);
        chk("wait_stb", {31'd0, stb[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        man_ack[0] = 1'b1;
        @(negedge clk);
        man_ack[0] = 1'b0;
        repeat (2) @(negedge clk);
        exp_words[0] = 0;
        exp_words[1] = 0;
        chk("kill_cyc", {31'd0, cyc[0]}, 32'd0);
        chk("kill_stb", {31'd0, stb[0]}, 32'd0);
        chk("kill_we", {28'd0, rwe[0]}, 32'd0);
        chk("kill_addr", {23'd0, raddr[0]}, 32'd0);
        chk("kill_data", rdata[0], 32'd0);
        chk("kill_busy", {31'd0, busy[0]}, 32'd0);
        chk("kill_ackrng", n_ack[0] - acks_before, 32'd0);
        chk("kill_words", {16'd0, words[0]}, 32'd0);
        hold[0] = 1'b0;
        collect(0, 9'h044, 0, 0, -1, 0);
        complete(0, 9'h044, 1, 32'd0, 0, 0);

        // Randomized words
        for (int k = 0; k < 10; k++) begin
            int i = k % 2;
            int st = $urandom_range(3);
            logic [8:0] a = 9'($urandom);
            comb_mode[i] = 1'($urandom_range(1));
            collect(i, a, 0, 1, -1, st);
            complete(i, a, 1, 32'd0, st, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rng_ram_filler.md
Name: rng_ram_filler

Overview:
- Upstream neighbour of the RAM-to-AES sequencer (ramfsm).
- On a per-word request (we_rng/addr_rng), collects 32 random bits from a serial entropy source, optionally applying Von Neumann debiasing.
- Writes the packed word into RAM port A over a pipelined Wishbone master.
- Pulses ack_rng when the RAM write has been acknowledged.

Parameters:
- ADDR_W, 9, RAM word address width.
- DATA_W, 32, word width; bit counter is clog2(DATA_W)+1 wide.
- DEBIAS, 1, 1 = Von Neumann pair debiasing; 0 = raw bits.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- we_rng  in  1  request: fill one word; sampled only in IDLE
- addr_rng  in  ADDR_W  target word address, latched with we_rng
- ack_rng  out  1  one-cycle pulse: word written
- entropy_bit_i  in  1  raw random bit
- entropy_valid_i  in  1  entropy_bit_i valid this cycle
- ram_cyc_a  out  1  Wishbone cycle
- ram_stb_a  out  1  Wishbone strobe
- ram_we_a  out  4  byte write enables
- ram_addr_a  out  ADDR_W  write address
- ram_data_in_a  out  DATA_W  write data
- ram_ack_a  in  1  Wishbone ack
- ram_stall_a  in  1  Wishbone stall
- busy_o  out  1  high in any state except IDLE
- words_written_o  out  16  count of completed words; wraps 16'hFFFF -> 0

Behaviour:
- Reset: all outputs 0, state IDLE, shift register, bit count and pair register cleared. Reset mid-operation drops cyc/stb immediately with no completion; an ack arriving afterwards is ignored.
- States: IDLE, COLLECT, WRITE, WAIT_ACK, DONE.
- IDLE:
  - we_rng=1 latches addr_rng, clears word/count/pair, goes to COLLECT.
  - we_rng in any other state is ignored (not queued).
- COLLECT, DEBIAS=0:
  - Each cycle with entropy_valid_i, word <= {word[DATA_W-2:0], entropy_bit_i} (first bit ends in MSB); count++.
- COLLECT, DEBIAS=1:
  - First valid bit of a pair is held.
  - On the second valid bit, pair 01 shifts in 0 and pair 10 shifts in 1; pairs 00 and 11 are discarded. The pair register clears either way.
- COLLECT exit: when the DATA_W-th bit is shifted in, go to WRITE. Bits arriving outside COLLECT are dropped, and no partial pair carries over between words.
- WRITE:
  - Asserts cyc=1, stb=1, we=4'hF, addr=latched address, data=word.
  - Hold everything while ram_stall_a=1.
  - At an edge with stall=0, the strobe is accepted: stb drops next cycle. If ram_ack_a is also 1 at that edge, go to DONE; otherwise go to WAIT_ACK.
- WAIT_ACK:
  - cyc=1, stb=0; wait indefinitely for ram_ack_a.
  - On ack: cyc=0, go to DONE.
- DONE: ack_rng=1 for exactly one cycle, words_written_o++, return to IDLE. A new we_rng is accepted from the following cycle.
- ram_we_a, ram_addr_a and ram_data_in_a are 0 whenever cyc=0.
- Latency, with DEBIAS=0, valid every cycle, no stall and a registered one-cycle ack:
  - we_rng sampled at edge T; bits sampled at edges T+1..T+32.
  - stb is high during cycle T+32..T+33.
  - ack_rng is high during cycle T+34..T+35.

Test Plan:
- DEBIAS=0, addr_rng=9'h005, bits 0xA5A5A5A5 MSB-first, valid every cycle, no stall, registered ack -> one write with ram_addr_a=9'h005, ram_data_in_a=32'hA5A5A5A5, ram_we_a=4'hF; ack_rng one pulse at edge T+35; words_written_o=1.
- DEBIAS=1, pair stream 01,00,10,11 repeated until 32 bits are produced -> word 32'h55555555 (MSB-first 0,1,...); 00/11 pairs consumed without effect.
- ram_stall_a held high for 5 cycles in WRITE -> cyc/stb/addr/data held stable for 6 cycles; exactly one accepted strobe; one ack_rng.
- Slave acks in the same cycle the strobe is accepted -> WAIT_ACK skipped; ack_rng on the next cycle; cyc dropped.
- we_rng re-asserted with addr 9'h1FF during COLLECT, and entropy_valid_i gaps of 3 cycles -> second request ignored, write goes to the original address, data unaffected by gaps.
- rst_i pulsed while in WAIT_ACK, then ram_ack_a arrives -> outputs 0, no ack_rng, words_written_o=0; the next request completes normally.
